// File: rtl/adder_mw_sched_if.sv
// Requester, response and shared-adder signals of the word-serial add scheduler.
// The scheduler is the slave; requesters, consumer and adder form the master.
interface adder_mw_sched_if #(
  parameter int N = 32,
  parameter int W = 4
);
  logic           req0_valid_i;
  logic           req0_ready_o;
  logic [N*W-1:0] req0_a_i;
  logic [N*W-1:0] req0_b_i;
  logic           req0_cin_i;
  logic           req1_valid_i;
  logic           req1_ready_o;
  logic [N*W-1:0] req1_a_i;
  logic [N*W-1:0] req1_b_i;
  logic           req1_cin_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [N*W-1:0] rsp_sum_o;
  logic           rsp_cout_o;
  logic           rsp_id_o;
  logic [N-1:0]   add_a_o;
  logic [N-1:0]   add_b_o;
  logic           add_cin_o;
  logic [N-1:0]   add_sum_i;
  logic           add_cout_i;
  logic           busy_o;

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_cin_i,
    input  req1_valid_i, req1_a_i, req1_b_i, req1_cin_i,
    input  rsp_ready_i, add_sum_i, add_cout_i,
    output req0_ready_o, req1_ready_o,
    output rsp_valid_o, rsp_sum_o, rsp_cout_o, rsp_id_o,
    output add_a_o, add_b_o, add_cin_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_cin_i,
    output req1_valid_i, req1_a_i, req1_b_i, req1_cin_i,
    output rsp_ready_i, add_sum_i, add_cout_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp_valid_o, rsp_sum_o, rsp_cout_o, rsp_id_o,
    input  add_a_o, add_b_o, add_cin_o, busy_o
  );
endinterface

// File: rtl/adder_mw_sched.sv
// Shares one N-bit external adder between two requesters, performing
// N*W-bit additions one word per cycle, LSW first, round-robin arbitrated.
module adder_mw_sched #(
  parameter int N = 32,
  parameter int W = 4
) (
  input logic clk_i,
  input logic rst_i,
  adder_mw_sched_if.slave bus
);
   localparam int KW = (W > 1) ? $clog2(W) : 1;
   localparam int NW = N * W;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [NW-1:0]   a_q;
   logic [NW-1:0]   b_q;
   logic [NW-N-1:0] res_q;
   logic [NW-1:0]   res_nxt;
   logic            carry_q;
   logic            id_q;
   logic            last_q;
   logic            idle;
   logic            run;
   logic            g0;
   logic            g1;

   assign idle = (state == IDLE) && !rst_i;
   assign run  = (state == RUN) && !rst_i;

   // Contention goes to whoever was not served last.
   assign g0 = idle && bus.req0_valid_i &&
               (!bus.req1_valid_i || last_q);
   assign g1 = idle && bus.req1_valid_i &&
               (!bus.req0_valid_i || !last_q);

   assign bus.req0_ready_o = g0;
   assign bus.req1_ready_o = g1;

   // Operands shift right each word so the adder always sees the low word.
   assign bus.add_a_o   = run ? a_q[N-1:0] : '0;
   assign bus.add_b_o   = run ? b_q[N-1:0] : '0;
   assign bus.add_cin_o = run ? carry_q : 1'b0;
   assign bus.busy_o    = (state != IDLE);

   assign res_nxt = {bus.add_sum_i, res_q};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         k               <= '0;
         a_q             <= '0;
         b_q             <= '0;
         res_q           <= '0;
         carry_q         <= 1'b0;
         id_q            <= 1'b0;
         last_q          <= 1'b1;
         bus.rsp_valid_o <= 1'b0;
         bus.rsp_sum_o   <= '0;
         bus.rsp_cout_o  <= 1'b0;
         bus.rsp_id_o    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (g0 || g1) begin
                  a_q     <= g1 ? bus.req1_a_i : bus.req0_a_i;
                  b_q     <= g1 ? bus.req1_b_i : bus.req0_b_i;
                  carry_q <= g1 ? bus.req1_cin_i : bus.req0_cin_i;
                  id_q    <= g1;
                  last_q  <= g1;
                  k       <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> N;
               b_q     <= b_q >> N;
               res_q   <= res_nxt[NW-1:N];
               carry_q <= bus.add_cout_i;
               k       <= k + 1'b1;
               if (k == KW'(W - 1)) begin
                  bus.rsp_sum_o   <= res_nxt;
                  bus.rsp_cout_o  <= bus.add_cout_i;
                  bus.rsp_id_o    <= id_q;
                  bus.rsp_valid_o <= 1'b1;
                  state           <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready_i) begin
                  bus.rsp_valid_o <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_mw_sched.sv
// Bench for adder_mw_sched: behavioural adder, queue-based requesters and
// a round-robin/arithmetic reference model.
module tb_adder_mw_sched;
   localparam int N  = 32;
   localparam int W  = 4;
   localparam int NW = N * W;

   typedef struct {
      logic [NW-1:0] a;
      logic [NW-1:0] b;
      logic          cin;
   } op_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   last_g = 1'b1;
   op_t  q0[$];
   op_t  q1[$];
   logic         run0_cin;
   logic [N-1:0] run0_a;

   always #5 clk_i = ~clk_i;

   adder_mw_sched_if #(.N(N), .W(W)) bus();

   adder_mw_sched #(.N(N), .W(W)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   assign {bus.add_cout_i, bus.add_sum_i} =
      {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o} + {{N{1'b0}}, bus.add_cin_o};

   task automatic chk(input string tag, input logic [160:0] obs,
                      input logic [160:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push(input bit who, input logic [NW-1:0] a,
                       input logic [NW-1:0] b, input logic cin);
      op_t o;
      o.a = a; o.b = b; o.cin = cin;
      if (who) q1.push_back(o);
      else q0.push_back(o);
   endtask

   task automatic drive_reqs();
      bus.req0_valid_i = (q0.size() > 0);
      bus.req0_a_i     = (q0.size() > 0) ? q0[0].a : '0;
      bus.req0_b_i     = (q0.size() > 0) ? q0[0].b : '0;
      bus.req0_cin_i   = (q0.size() > 0) ? q0[0].cin : 1'b0;
      bus.req1_valid_i = (q1.size() > 0);
      bus.req1_a_i     = (q1.size() > 0) ? q1[0].a : '0;
      bus.req1_b_i     = (q1.size() > 0) ? q1[0].b : '0;
      bus.req1_cin_i   = (q1.size() > 0) ? q1[0].cin : 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      bus.req0_valid_i = 1'b1;
      bus.req1_valid_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("rst_ready", {bus.req1_ready_o, bus.req0_ready_o}, 0);
      chk("rst_rsp", {bus.rsp_valid_o, bus.rsp_cout_o, bus.rsp_id_o,
                      bus.rsp_sum_o}, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_add", {bus.add_a_o, bus.add_b_o, bus.add_cin_o}, 0);
      rst_i  = 1'b0;
      last_g = 1'b1;
      drive_reqs();
   endtask

   // Serve nops operations from the queues; bp = cycles of response stall.
   task automatic serve(input int nops, input int bp);
      op_t o;
      logic [NW:0] exp;
      bit exp_id;
      int n;
      logic [160:0] snap;
      for (int t = 0; t < nops; t++) begin
         drive_reqs();
         #1;
         exp_id = (q0.size() > 0 && q1.size() > 0) ? ~last_g : (q1.size() > 0);
         n = 0;
         while (!(bus.req0_ready_o || bus.req1_ready_o) && n < 5) begin
            @(negedge clk_i); #1; n++;
         end
         chk("grant", {bus.req1_ready_o, bus.req0_ready_o}, exp_id ? 2 : 1);
         if (n == 5) return;
         o = exp_id ? q1.pop_front() : q0.pop_front();
         last_g = exp_id;
         exp = o.a + o.b + o.cin;
         @(posedge clk_i); #1;
         drive_reqs();
         n = 0;
         while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk_i); n++;
            if (n == 1) begin
               run0_cin = bus.add_cin_o;
               run0_a   = bus.add_a_o;
            end
            chk("ready_busy", {bus.req1_ready_o, bus.req0_ready_o}, 0);
         end
         chk("latency", n, W + 1);
         chk("sum", bus.rsp_sum_o, exp[NW-1:0]);
         chk("cout", bus.rsp_cout_o, exp[NW]);
         chk("id", bus.rsp_id_o, exp_id);
         snap = {bus.rsp_valid_o, bus.rsp_cout_o, bus.rsp_id_o, bus.rsp_sum_o};
         repeat (bp) begin
            @(negedge clk_i);
            chk("bp_hold", {bus.rsp_valid_o, bus.rsp_cout_o, bus.rsp_id_o,
                            bus.rsp_sum_o}, snap);
            chk("bp_ready", {bus.req1_ready_o, bus.req0_ready_o}, 0);
         end
         bus.rsp_ready_i = 1'b1;
         @(posedge clk_i); #1;
         bus.rsp_ready_i = 1'b0;
         @(negedge clk_i);
      end
   endtask

   initial begin
      bus.rsp_ready_i = 1'b0;
      drive_reqs();
      do_reset();

      push(0, {NW{1'b1}}, 1, 0);
      serve(1, 0);
      push(1, 128'h00000000_00000000_00000000_FFFFFFFF, 1, 0);
      serve(1, 0);
      push(0, 0, 0, 1);
      serve(1, 0);
      chk("run0_cin", run0_cin, 1);
      chk("run0_a", run0_a, 0);

      push(0, rnd(), rnd(), 1'($urandom));
      push(1, rnd(), rnd(), 1'($urandom));
      serve(2, 10);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(0, rnd(), rnd(), 1'($urandom));
         push(1, rnd(), rnd(), 1'($urandom));
      end
      serve(8, $urandom_range(0, 3));

      do_reset();
      push(0, rnd(), rnd(), 1);
      drive_reqs();
      #1;
      chk("mid_grant", {bus.req1_ready_o, bus.req0_ready_o}, 1);
      @(posedge clk_i); #1;
      void'(q0.pop_front());
      drive_reqs();
      repeat (3) @(negedge clk_i);
      chk("mid_busy", bus.busy_o, 1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i  = 1'b0;
      last_g = 1'b1;
      @(negedge clk_i);
      chk("mid_idle", {bus.rsp_valid_o, bus.busy_o}, 0);
      repeat (10) begin
         @(negedge clk_i);
         chk("mid_norsp", bus.rsp_valid_o, 0);
      end
      push(0, rnd(), rnd(), 0);
      serve(1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
